// File: rtl/mips_pkg.sv
// Shared definitions for the stream multiplexer: selection-mode encodings
// and a helper that locates one channel inside a flattened data bus.
package mips_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Low bit position of channel idx in a flattened bus of width-bit channels.
    function automatic int chan_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority request search: the first requesting channel found when
// scanning ptr, ptr+1, ... (wrapping modulo N) wins. Purely combinational.
module rr_arbiter #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int cand_s;

    // Scan all channels starting at ptr and keep the first one that requests.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = {SEL_W{1'b0}};
        cand_s    = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = int'(ptr) + k;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_valid && req[cand_s]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(cand_s);
            end else begin
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Channel choice is either the sel input (fixed mode) or a rotating
// round-robin among valid inputs. in_ready is combinational; the output
// register never sees out_ready on its data path.
module stream_mux_rr
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] ONE_CHAN  = SEL_W'(1);

    logic             load_en_s;
    logic             arb_valid_s;
    logic [SEL_W-1:0] arb_idx_s;
    logic             grant_valid_s;
    logic [SEL_W-1:0] grant_s;
    logic [N-1:0]     in_ready_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;

    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] rr_ptr_r;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_r),
        .gnt_valid (arb_valid_s),
        .gnt_idx   (arb_idx_s)
    );

    // Output register may accept a beat when empty or drained this cycle.
    assign load_en_s = !out_valid_r || out_ready;

    // Pick the granted channel: arbiter result in RR mode, sel in fixed mode
    // (an out-of-range sel, possible when N is not a power of two, grants nothing).
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = {SEL_W{1'b0}};
        if (mode == MODE_RR) begin
            grant_valid_s = arb_valid_s;
            grant_s       = arb_idx_s;
        end else begin
            grant_valid_s = (int'(sel) < N);
            grant_s       = sel;
        end
    end

    // One-hot ready toward the granted channel and the data of that channel.
    always_comb begin
        in_ready_s = {N{1'b0}};
        sel_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (load_en_s && grant_valid_s && (grant_s == SEL_W'(i)) && !rst) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
            if (grant_s == SEL_W'(i)) begin
                sel_data_s = in_data[chan_lo(i, WIDTH) +: WIDTH];
            end else begin
            end
        end
    end

    assign xfer_s   = |(in_ready_s & in_valid);
    assign in_ready = in_ready_s;

    // Output register and round-robin pointer: load on transfer, clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            rr_ptr_r    <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            out_data_r  <= sel_data_s;
            out_chan_r  <= grant_s;
            out_valid_r <= 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_r <= (grant_s == LAST_CHAN) ? {SEL_W{1'b0}} : grant_s + ONE_CHAN;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr. The stimulus process runs a simple
// behavioural model (occupancy flag + rotating pointer) to predict in_ready
// and pushes every expected accepted beat into a queue; an independent
// monitor pops and compares whenever the DUT presents a beat.
module tb_stream_mux_rr;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] data;
        int           chan;
        int           due;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic [1:0]     sel = 2'd0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = 4'b1111;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_valid;
    logic           out_ready = 1'b1;

    logic           rst3 = 1'b1;
    logic           mode3 = 1'b0;
    logic [1:0]     sel3 = 2'd0;
    logic [3*W-1:0] in_data3 = '0;
    logic [2:0]     in_valid3 = 3'b000;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_chan3;
    logic           out_valid3;
    logic           out_ready3 = 1'b1;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    beat_t q[$];
    bit    m_full = 1'b0;
    int    m_ptr = 0;

    stream_mux_rr #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle of stimulus plus model prediction.
    task automatic step(input logic r, input logic md, input logic [1:0] s,
                        input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
        int g;
        bit gv;
        bit ld;
        logic [N-1:0] exp_rdy;
        beat_t b;
        @(negedge clk);
        rst = r; mode = md; sel = s; in_valid = v; out_ready = ordy; in_data = d;
        #1;
        ld = !m_full || ordy;
        gv = 1'b0;
        g = 0;
        if (md) begin
            for (int j = 0; j < N; j++) begin
                if (!gv && v[(m_ptr + j) % N]) begin
                    gv = 1'b1;
                    g = (m_ptr + j) % N;
                end
            end
        end else begin
            g = int'(s);
            gv = (g < N);
        end
        exp_rdy = (ld && gv && !r) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (r) begin
            m_full = 1'b0;
            m_ptr = 0;
        end else if (ld && gv && v[g]) begin
            b.data = d[g*W +: W];
            b.chan = g;
            b.due = cyc + 1;
            q.push_back(b);
            m_full = 1'b1;
            if (md) m_ptr = (g + 1) % N;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        if (r) q.delete();
    endtask

    // Monitor: compare the presented beat with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            checks++;
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got chan=%0d data=%h expected no beat", out_chan, out_data);
                end else begin
                    if (q[0].due > cyc || out_data !== q[0].data || int'(out_chan) != q[0].chan) begin
                        errors++;
                        $display("FAIL beat: got chan=%0d data=%h expected chan=%0d data=%h (due cycle %0d, now %0d)",
                                 out_chan, out_data, q[0].chan, q[0].data, q[0].due, cyc);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                if (q.size() != 0 && q[0].due <= cyc) begin
                    errors++;
                    $display("FAIL missing_beat: got out_valid=%b expected chan=%0d data=%h", out_valid, q[0].chan, q[0].data);
                end
            end
        end
    end

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    function automatic logic [N*W-1:0] pattern(input logic [W-1:0] base);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = base + W'(i);
        return d;
    endfunction

    initial begin
        logic       rm;
        logic [1:0] rs;
        logic [N*W-1:0] d;

        // Reset with every channel valid.
        step(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, rand_data());
        step(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, rand_data());
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_chan", 64'(out_chan), 64'd0);

        // Fixed mode, sel=2.
        d = pattern(32'hA5A5_0000);
        step(1'b0, 1'b0, 2'd2, 4'b1111, 1'b1, d);
        chk("fixed_out_data", 64'(out_data), 64'h0000_0000_A5A5_0002);
        chk("fixed_out_chan", 64'(out_chan), 64'd2);
        chk("fixed_out_valid", 64'(out_valid), 64'd1);

        // Backpressure for three cycles, then release with a new beat.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 2'd2, 4'b1111, 1'b0, rand_data());
        chk("held_out_data", 64'(out_data), 64'h0000_0000_A5A5_0002);
        step(1'b0, 1'b0, 2'd1, 4'b1111, 1'b1, d);
        chk("reload_out_valid", 64'(out_valid), 64'd1);
        chk("reload_out_chan", 64'(out_chan), 64'd1);

        // Round-robin with all valid: 0,1,2,3,0,1.
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, pattern(32'h0000_0100));
        chk("rr_last_chan", 64'(out_chan), 64'd1);
        chk("rr_last_data", 64'(out_data), 64'h0000_0000_0000_0101);

        // Sparse round-robin, then a single requester, then none.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2'd0, 4'b1010, 1'b1, rand_data());
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1, rand_data());
        chk("single_chan", 64'(out_chan), 64'd1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, rand_data());
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Reset while a beat is held under backpressure.
        step(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1, rand_data());
        step(1'b0, 1'b0, 2'd3, 4'b1111, 1'b0, rand_data());
        step(1'b1, 1'b0, 2'd3, 4'b1111, 1'b0, rand_data());
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1, rand_data());
        chk("post_reset_rr_chan", 64'(out_chan), 64'd0);
        chk("post_reset_rr_valid", 64'(out_valid), 64'd1);

        // Randomized traffic with mode/sel changes and occasional resets.
        rm = 1'b1;
        rs = 2'd0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) rm = ~rm;
            if ($urandom_range(0, 9) == 0) rs = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 99) == 0), rm, rs, 4'($urandom),
                 ($urandom_range(0, 3) != 0), rand_data());
        end

        // Drain and confirm the scoreboard empties.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1, rand_data());
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        // Three-channel build: out-of-range sel grants nothing.
        @(negedge clk);
        rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("n3_sel3_in_ready", 64'(in_ready3), 64'd0);
            @(posedge clk);
            #1;
            chk("n3_sel3_out_valid", 64'(out_valid3), 64'd0);
            @(negedge clk);
        end
        sel3 = 2'd1;
        #1;
        chk("n3_sel1_in_ready", 64'(in_ready3), 64'b010);
        @(posedge clk);
        #1;
        chk("n3_sel1_out_valid", 64'(out_valid3), 64'd1);
        chk("n3_sel1_out_data", 64'(out_data3), 64'h0000_0000_C0DE_0001);
        chk("n3_sel1_out_chan", 64'(out_chan3), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
